// File: rtl/mem_loader_pkg.sv
// mem_loader shared types.
// State encoding and counter-width helper.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAKE,
    S_START,
    S_SHIFT,
    S_DONE
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_loader_piso.sv
// Word shift register plus one-word hold buffer.
// Feeds the serial line one bit per cycle.
module mem_loader_piso
  import mem_loader_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             reload_i,
  input  logic             accept_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             bit_o,
  output logic             hold_valid_o,
  output logic             underrun_o
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;

  assign underrun_o = reload_i && !hold_valid_o;

  // at a word boundary the next bit comes straight from the hold slot
  assign bit_o = reload_i ? (hold_valid_o & hold[0]) : sreg[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg         <= '0;
      hold         <= '0;
      hold_valid_o <= 1'b0;
    end else begin
      unique case (1'b1)
        load_i:   sreg <= word_i;
        reload_i: sreg <= hold_valid_o ? (hold >> 1) : '0;
        shift_i:  sreg <= sreg >> 1;
        default: ;
      endcase
      if (clear_i) begin
        hold_valid_o <= 1'b0;
      end else if (accept_i) begin
        hold         <= word_i;
        hold_valid_o <= 1'b1;
      end else if (reload_i) begin
        hold_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Serial programmer for the single-wire lookup memory.
// Streams wake/start preamble then DEPTH words LSB first.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             programmed_i,
  input  logic             word_valid_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             word_ready_o,
  output logic             data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int BW = cnt_w(WIDTH);
  localparam int DW = cnt_w(DEPTH);
  localparam int AW = cnt_w(DEPTH + 1);

  state_e        state;
  logic [BW-1:0] bit_idx;
  logic [DW-1:0] word_idx;
  logic [AW-1:0] acc_cnt;

  logic in_load;
  logic fetch_hs;
  logic hold_hs;
  logic bit_last;
  logic word_last;
  logic clear;
  logic shift;
  logic reload;
  logic piso_bit;
  logic hold_valid;
  logic underrun;

  assign busy_o    = (state != S_IDLE);
  assign in_load   = (state == S_WAKE) || (state == S_START)
                  || (state == S_SHIFT);
  assign bit_last  = (bit_idx == BW'(WIDTH - 1));
  assign word_last = (word_idx == DW'(DEPTH - 1));
  assign fetch_hs  = (state == S_FETCH) && word_valid_i;
  assign hold_hs   = in_load && word_valid_i && word_ready_o;
  assign clear     = (state == S_IDLE) && start_i;
  assign shift     = (state == S_START)
                  || ((state == S_SHIFT) && !bit_last);
  assign reload    = (state == S_SHIFT) && bit_last && !word_last;

  // words beyond DEPTH per load are refused
  always_comb begin
    word_ready_o = 1'b0;
    unique case (1'b1)
      state == S_FETCH: word_ready_o = 1'b1;
      in_load: word_ready_o = !hold_valid
                           && (acc_cnt < AW'(DEPTH));
      default: ;
    endcase
  end

  mem_loader_piso #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear),
    .load_i       (fetch_hs),
    .shift_i      (shift),
    .reload_i     (reload),
    .accept_i     (hold_hs),
    .word_i       (word_i),
    .bit_o        (piso_bit),
    .hold_valid_o (hold_valid),
    .underrun_o   (underrun)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      data_o   <= 1'b0;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
      bit_idx  <= '0;
      word_idx <= '0;
      acc_cnt  <= '0;
    end else begin
      done_o <= 1'b0;
      if (fetch_hs || hold_hs) begin
        acc_cnt <= acc_cnt + AW'(1);
      end
      unique case (state)
        S_IDLE: begin
          data_o <= 1'b0;
          if (start_i) begin
            state    <= S_FETCH;
            error_o  <= 1'b0;
            bit_idx  <= '0;
            word_idx <= '0;
            acc_cnt  <= '0;
          end
        end
        S_FETCH: begin
          data_o <= 1'b0;
          if (word_valid_i) begin
            data_o <= 1'b1;
            state  <= programmed_i ? S_WAKE : S_START;
          end
        end
        S_WAKE: begin
          data_o <= 1'b1;
          state  <= S_START;
        end
        S_START: begin
          data_o <= piso_bit;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (!bit_last) begin
            data_o  <= piso_bit;
            bit_idx <= bit_idx + BW'(1);
          end else if (!word_last) begin
            // an empty hold slot shifts zeros to keep alignment
            data_o   <= piso_bit;
            bit_idx  <= '0;
            word_idx <= word_idx + DW'(1);
            if (underrun) begin
              error_o <= 1'b1;
            end
          end else begin
            data_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          data_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          data_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
